// File: rtl/seq_alu.sv
// seq_alu: multi-cycle, handshaked, area-reduced ALU.
// Add, subtract and compare run through a bit-serial ripple carry chain, LSB first.
// Shifts move one bit position per cycle.
// The opcode encodings below mirror the parameters.vh opcode macros.
// Optional build macro SEQ_ALU_FLAGS_EN adds the flag_carry and flag_zero outputs.
//
// state | meaning
// IDLE  | waiting for start with alu_enable high
// EXEC  | operation in progress; busy is high
module seq_alu #(
  parameter int WORD_SIZE = 16,
  parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alu_enable,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WORD_SIZE-1:0] input1,
  input  logic [WORD_SIZE-1:0] input2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] alu_out
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic                 flag_carry,
  output logic                 flag_zero
`endif
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_COMP = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_SLI  = 5'd9;
  localparam logic [4:0] OP_SRI  = 5'd10;

  localparam logic [WORD_SIZE-1:0] W_LIM = WORD_SIZE'(WORD_SIZE);

  typedef enum logic {IDLE, EXEC} state_t;
  // K_SINGLE covers logic ops, degenerate shifts and undefined opcodes
  typedef enum logic [1:0] {K_SINGLE, K_ARITH, K_SHIFT} kind_t;

  state_t               state;
  kind_t                kind;
  logic [4:0]           op_q;
  logic [WORD_SIZE-1:0] a_q, b_q, res_q;
  logic [SHAMT_W-1:0]   cnt;
  logic                 carry;

  logic                 sum_bit, cout, shift_out, is_last, is_sub;
  logic [WORD_SIZE-1:0] arith_fin, shift_next, single_res, fin;

  // Serial adder slice, shifter step and single-cycle result
  always_comb begin
    sum_bit    = a_q[0] ^ b_q[0] ^ carry;
    cout       = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);
    arith_fin  = {sum_bit, res_q[WORD_SIZE-1:1]};
    shift_next = (op_q == OP_SLI) ? (a_q << 1) : (a_q >> 1);
    shift_out  = (op_q == OP_SLI) ? a_q[WORD_SIZE-1] : a_q[0];
    is_sub     = (opcode == OP_SUB) || (opcode == OP_COMP);
    is_last    = (kind == K_SINGLE) || (cnt == '0);
    case (op_q)
      OP_AND, OP_ANDI: single_res = a_q & b_q;
      OP_OR:           single_res = a_q | b_q;
      OP_XOR:          single_res = a_q ^ b_q;
      OP_NOT:          single_res = ~a_q;
      // only n=0 (pass A) or n>=WORD_SIZE (all zero) reach here as single
      OP_SLI, OP_SRI:  single_res = (b_q == '0) ? a_q : '0;
      default:         single_res = '0;
    endcase
    case (kind)
      K_SINGLE: fin = single_res;
      K_ARITH:  fin = (op_q == OP_COMP) ? {{(WORD_SIZE-1){1'b0}}, (arith_fin == '0)}
                                        : arith_fin;
      K_SHIFT:  fin = shift_next;
      default:  fin = '0;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic fin_carry;

  // Carry flag source depends on operation class
  always_comb begin
    case (kind)
      K_ARITH: fin_carry = cout;
      K_SHIFT: fin_carry = shift_out;
      default: fin_carry = 1'b0;
    endcase
  end

  // Flags update together with alu_out on the completing edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (state == EXEC && is_last) begin
      flag_carry <= fin_carry;
      flag_zero  <= (fin == '0);
    end
  end
`else
  // Without flags the MSB carry-out is simply dropped
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      kind    <= K_SINGLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && alu_enable) begin
            state <= EXEC;
            busy  <= 1'b1;
            op_q  <= opcode;
            a_q   <= input1;
            b_q   <= is_sub ? ~input2 : input2;
            carry <= is_sub;
            res_q <= '0;
            case (opcode)
              OP_ADD, OP_ADDI, OP_SUB, OP_COMP: begin
                kind <= K_ARITH;
                cnt  <= SHAMT_W'(WORD_SIZE - 1);
              end
              OP_SLI, OP_SRI: begin
                if (input2 == '0 || input2 >= W_LIM) begin
                  kind <= K_SINGLE;
                end else begin
                  kind <= K_SHIFT;
                  cnt  <= SHAMT_W'(input2) - SHAMT_W'(1);
                end
              end
              default: kind <= K_SINGLE;
            endcase
          end
        end
        EXEC: begin
          cnt <= cnt - SHAMT_W'(1);
          if (kind == K_ARITH) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= arith_fin;
            carry <= cout;
          end else if (kind == K_SHIFT) begin
            a_q <= shift_next;
          end
          if (is_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            alu_out <= fin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu with directed vectors.
module tb_seq_alu;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_COMP = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_SLI  = 5'd9;
  localparam logic [4:0] OP_SRI  = 5'd10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_enable = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] input1 = '0;
  logic [15:0] input2 = '0;
  logic        busy, done;
  logic [15:0] alu_out;
`ifdef SEQ_ALU_FLAGS_EN
  logic        flag_carry, flag_zero;
`endif

  seq_alu #(.WORD_SIZE(16)) dut (
    .clock(clock), .reset_n(reset_n), .alu_enable(alu_enable), .start(start),
    .opcode(opcode), .input1(input1), .input2(input2),
    .busy(busy), .done(done), .alu_out(alu_out)
`ifdef SEQ_ALU_FLAGS_EN
    , .flag_carry(flag_carry), .flag_zero(flag_zero)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        fc;
    logic        fz;
    int          due;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", alu_out, e.res);
        check("done_cycle", cyc, e.due);
        check("busy_at_done", busy, 1'b0);
`ifdef SEQ_ALU_FLAGS_EN
        check("flag_carry", flag_carry, e.fc);
        check("flag_zero", flag_zero, e.fz);
`endif
      end
    end
  end

  task automatic push(input logic [15:0] res, input logic fc, input logic fz, input int n);
    exp_t e;
    e.res = res; e.fc = fc; e.fz = fz; e.due = cyc + 1 + n;
    sb.push_back(e);
  endtask

  // Called at a negedge: one-cycle start pulse, then operands are scrambled
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic fc, input logic fz, input int n);
    alu_enable = 1'b1;
    start = 1'b1; opcode = op; input1 = a; input2 = b;
    push(res, fc, fz, n);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    input1 = ~a; input2 = 16'h0003; opcode = OP_NOT;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b, res;
    logic        fc, fz;
    int          n;
  } vec_t;

  vec_t vecs[$] = '{
    '{OP_ADD,  16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0, 16},
    '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 16},
    '{OP_SUB,  16'h1234, 16'h5678, 16'hBBBC, 1'b0, 1'b0, 16},
    '{OP_COMP, 16'h1234, 16'h1234, 16'h0001, 1'b1, 1'b0, 16},
    '{OP_COMP, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 16},
    '{OP_ADDI, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 16},
    '{OP_SRI,  16'h8000, 16'h0001, 16'h4000, 1'b0, 1'b0, 1},
    '{OP_SLI,  16'h00FF, 16'h0008, 16'hFF00, 1'b0, 1'b0, 8},
    '{OP_SRI,  16'hFFFF, 16'h0010, 16'h0000, 1'b0, 1'b1, 1},
    '{OP_SLI,  16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1},
    '{OP_SRI,  16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b1, 2},
    '{OP_SRI,  16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1},
    '{OP_SLI,  16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 15},
    '{OP_AND,  16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1},
    '{OP_ANDI, 16'hF0F0, 16'h00FF, 16'h00F0, 1'b0, 1'b0, 1},
    '{OP_OR,   16'hA000, 16'h0005, 16'hA005, 1'b0, 1'b0, 1},
    '{OP_NOT,  16'h0F0F, 16'h1234, 16'hF0F0, 1'b0, 1'b0, 1},
    '{5'd31,   16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1}
  };

  initial begin
    logic busy_seen;
    repeat (2) @(negedge clock);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_alu_out", alu_out, 16'h0000);
    reset_n = 1'b1;
    @(negedge clock);

    // start with alu_enable low must be ignored
    alu_enable = 1'b0; start = 1'b1; opcode = OP_ADD; input1 = 16'hAAAA; input2 = 16'h5555;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
    start = 1'b0;
    check("disabled_busy", busy_seen, 1'b0);
    check("disabled_alu_out", alu_out, 16'h0000);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fc, vecs[i].fz, vecs[i].n);
      wait_idle();
    end

    // start while busy is dropped; only the ADD completes
    issue(OP_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 16);
    repeat (3) @(negedge clock);
    start = 1'b1; opcode = OP_XOR; input1 = 16'h0F0F; input2 = 16'h00FF;
    @(negedge clock);
    start = 1'b0;
    alu_enable = 1'b0;
    wait_idle();

    // start held through the done cycle: second op accepted on the next edge
    alu_enable = 1'b1;
    start = 1'b1; opcode = OP_ADD; input1 = 16'h0001; input2 = 16'h0002;
    push(16'h0003, 1'b0, 1'b0, 16);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) break;
    end
    check("b2b_first_done", done, 1'b1);
    opcode = OP_XOR; input1 = 16'h0F0F; input2 = 16'h00FF;
    push(16'h0FF0, 1'b0, 1'b0, 1);
    @(negedge clock);
    start = 1'b0;
    check("b2b_second_busy", busy, 1'b1);
    wait_idle();

    // reset on cycle 7 of an ADD aborts it without a done pulse
    start = 1'b1; opcode = OP_ADD; input1 = 16'h4321; input2 = 16'h1111;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_alu_out", alu_out, 16'h0000);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("abort_no_busy", busy, 1'b0);

    issue(OP_NOT, 16'h5A5A, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle, handshaked ALU. It is the responding end of the opcode/operand/result interface that processor control and benches drive.
- Accepts one operation per start pulse and executes it over one or more cycles:
  - add, subtract and compare use a bit-serial ripple carry chain;
  - shifts move one bit position per cycle.
- Returns a registered result with a one-cycle done pulse.
- Serves as the area-reduced ALU option for the binary core. Uses the opcode macros from parameters.vh.

Parameters:
- WORD_SIZE, 16, operand/result width in bits (power of two, ≥4).
- SHAMT_W, $clog2(WORD_SIZE), internal shift-counter width.

Ports:
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous active-low reset
- alu_enable  input  1  block enable; start ignored while low
- start  input  1  request strobe, sampled on rising edge
- opcode  input  5  operation select (parameters.vh macros)
- input1  input  WORD_SIZE  operand A / shift source
- input2  input  WORD_SIZE  operand B / immediate / shift amount
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- alu_out  output  WORD_SIZE  registered result, held until next done

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; busy=0, done=0, alu_out=0; internal counters and carry cleared. Reset mid-operation aborts it, and no done is produced.
- States: IDLE, EXEC.
- IDLE → EXEC on a rising edge with start=1 and alu_enable=1 (accept edge).
  - On the accept edge: latch opcode, input1, input2; busy=1 from that edge on.
  - Operand changes after the accept edge have no effect.
- start while busy=1 is ignored and not queued.
- start with alu_enable=0 is ignored in any state. alu_enable dropping during EXEC does not abort the operation.
- EXEC duration N (cycles from the accept edge to the completing edge):
  - NOT, AND, OR, XOR, ANDI: N=1.
  - ADD, ADDI, SUB, COMP: N=WORD_SIZE. Bit i is processed on cycle i, LSB first, with a 1-bit carry register.
    - SUB = A + ~B with carry-in 1.
    - COMP computes A−B serially. Result 1 if all difference bits are zero, else 0.
  - SRI/SLI: logical shift of A by n = input2 (full value). Zero fill.
    - n=0: N=1, result A.
    - 1≤n<WORD_SIZE: N=n, one bit per cycle.
    - n≥WORD_SIZE: N=1, result 0.
  - Undefined opcode: N=1, result 0.
- Completing edge: alu_out ← result, done=1 for exactly one cycle, busy=0, state → IDLE.
- Back-to-back: start high during the done cycle is accepted on the next edge.
- Arithmetic is modulo 2^WORD_SIZE. Carry/borrow out of the MSB is discarded unless the optional feature is enabled.
- ADDI and ANDI use input2 as the immediate, already extended by the decoder.
- alu_out changes only on the completing edge or on reset.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined: adds two output ports, both updated on the completing edge together with alu_out and reset to 0.
  - flag_carry (1 bit): MSB carry-out for ADD/ADDI; carry-out of A + ~B + 1 for SUB/COMP (1 = no borrow); last bit shifted out for SRI/SLI (0 when n=0 or n≥WORD_SIZE); 0 for logic ops.
  - flag_zero (1 bit): 1 when the result is all zeros.
- Undefined: ports absent, no flag logic, MSB carry discarded.

Test Plan:
- Reset, then start=1 with alu_enable=0, ADD, 0xAAAA + 0x5555 → busy stays 0, no done, alu_out stays 0x0000.
- ADD 0x1234 + 0x5678 → busy high 16 cycles, done pulse on the 16th edge after accept, alu_out=0x68AC. Repeat 0xFFFF + 0x0001 → 0x0000 (flag_carry=1, flag_zero=1 when SEQ_ALU_FLAGS_EN).
- SUB 0x1234 − 0x5678 → 0xBBBC after 16 cycles. COMP 0x1234,0x1234 → 0x0001. COMP 0x1234,0x5678 → 0x0000.
- SRI 0x8000 by 1 → 0x4000, done 1 cycle after accept. SLI 0x00FF by 8 → 0xFF00, done 8 cycles after accept. SRI 0xFFFF by 16 → 0x0000 in 1 cycle. AND 0xAAAA,0x5555 → 0x0000 in 1 cycle.
- Protocol boundaries:
  - During an ADD, pulse start with XOR operands → ignored; the ADD result is delivered.
  - Start held high in the done cycle → the second operation is accepted immediately.
- Assert reset_n low at cycle 7 of an ADD → busy=0 and alu_out=0 immediately, no done. After release, a NOT of 0x5A5A → 0xA5A5.
